// File: rtl/stage_memory.sv
// Memory-access stage: forwards non-memory instructions, and drives one data-cache
// request/acknowledge transaction per LOAD/STORE while stalling upstream.
package stage_memory_pkg;
  typedef enum logic [2:0] {NOP, ADD, AHI, SUB, LOAD, STORE, BRANCH} t_op;

  typedef struct packed {
    logic        valid;
    t_op         operation;
    logic [4:0]  rd;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] result;
  } t_stage;

  localparam t_stage stage_flush = '{valid: 1'b0, operation: NOP, rd: '0,
                                     v1: '0, v2: '0, result: '0};
endpackage

module stage_memory
  import stage_memory_pkg::*;
#(
  parameter int unsigned WAIT_CNT_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall_in,
  input  t_stage                stage_ex,
  output logic                  stall_out,
  output t_stage                stage_mem,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic [WAIT_CNT_W-1:0] mem_wait_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                  state_q, state_d;
  t_stage                  stage_q, stage_d;
  t_stage                  held_q, held_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;

  logic   is_mem;
  t_stage ack_res;

  assign is_mem = (stage_ex.operation == LOAD) || (stage_ex.operation == STORE);

  // stage_ex is held stable by stall_out throughout WAIT, so the result is built from it at ack time.
  always_comb begin
    ack_res        = stage_ex;
    ack_res.result = (stage_ex.operation == LOAD) ? mem_rdata : stage_ex.v2;
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    held_d  = held_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (!stall_in) begin
          if (is_mem) begin
            req_d   = 1'b1;
            we_d    = (stage_ex.operation == STORE);
            addr_d  = stage_ex.v1;
            wdata_d = stage_ex.v2;
            stage_d = stage_flush;
            state_d = S_WAIT;
          end else begin
            stage_d = stage_ex;
          end
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          req_d = 1'b0;
          if (!stall_in) begin
            stage_d = ack_res;
            state_d = S_IDLE;
          end else begin
            held_d  = ack_res;
            state_d = S_DONE;
          end
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + WAIT_CNT_W'(1);
        end
      end
      S_DONE: begin
        if (!stall_in) begin
          stage_d = held_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      stage_q <= stage_flush;
      held_q  <= stage_flush;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      held_q  <= held_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_out = stall_in
                   | ((state_q == S_IDLE) & is_mem)
                   | ((state_q == S_WAIT) & ~mem_ack)
                   | (state_q == S_DONE);

  assign stage_mem       = stage_q;
  assign mem_req         = req_q;
  assign mem_we          = we_q;
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_wait_cycles = cnt_q;

endmodule
